uc_seq: RTL and testbench

- Sequencing control unit for the single-cycle 8-bit datapath.
- Decodes the 6-bit opcode and the z flag into the datapath control strobes for the current instruction.
- Adds run/halt/single-step debug control, call-depth tracking with stack overflow/underflow traps, and a retired-instruction counter.
- Drives pc_en, which the datapath revision routes to the PC register load enable.

---
 rtl/uc_seq_if.sv | 29 ++
 rtl/uc_seq.sv | 191 +++++++++++++++++++
 tb/tb_uc_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_seq_if.sv
// Control bus between the sequencing unit and the 8-bit datapath:
// instruction/flag inputs to the controller and its strobe outputs.
interface uc_seq_if;
   logic [5:0] opcode;
   logic       z;
   logic       s_inc;
   logic       s_inm;
   logic       we3;
   logic       wez;
   logic       s_pila;
   logic       push;
   logic       pop;
   logic       we4;
   logic       s_data;
   logic [2:0] op_alu;
   logic       pc_en;

   modport master (
      input  opcode, z,
      output s_inc, s_inm, we3, wez, s_pila,
      output push, pop, we4, s_data, op_alu, pc_en
   );

   modport slave (
      output opcode, z,
      input  s_inc, s_inm, we3, wez, s_pila,
      input  push, pop, we4, s_data, op_alu, pc_en
   );
endinterface

// File: rtl/uc_seq.sv
// Sequencing control unit: opcode decode, run/halt/step debug control,
// call-depth traps and a retired-instruction counter.
module uc_seq #(
   parameter int STACK_DEPTH = 8,
   parameter int DW          = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   uc_seq_if.master         bus,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             halt_req,
   output logic             halted,
   output logic [1:0]       err,
   output logic [DW-1:0]    depth,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT,
      ST_STEP
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UNF  = 2'b10;
   localparam logic [1:0] ERR_ILL  = 2'b11;

   state_t           state_q;
   state_t           state_d;
   logic [1:0]       err_q;
   logic [1:0]       err_d;
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    depth_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic is_alu;
   logic is_li;
   logic is_ld;
   logic is_st;
   logic is_j;
   logic is_jz;
   logic is_jnz;
   logic is_call;
   logic is_ret;
   logic is_hlt;
   logic legal;

   logic       exec;
   logic       ovf;
   logic       unf;
   logic       trap;
   logic       retire;
   logic [1:0] trap_code;

   assign is_alu  = (bus.opcode[5:3] == 3'b000);
   assign is_li   = (bus.opcode == 6'b001000);
   assign is_ld   = (bus.opcode == 6'b001001);
   assign is_st   = (bus.opcode == 6'b001010);
   assign is_j    = (bus.opcode == 6'b010000);
   assign is_jz   = (bus.opcode == 6'b010001);
   assign is_jnz  = (bus.opcode == 6'b010010);
   assign is_call = (bus.opcode == 6'b010011);
   assign is_ret  = (bus.opcode == 6'b010100);
   assign is_hlt  = (bus.opcode == 6'b111111);

   assign legal = is_alu | is_li | is_ld | is_st
                | is_j | is_jz | is_jnz
                | is_call | is_ret | is_hlt;

   // Reset suppresses execution so an aborted instruction never writes.
   assign exec   = !reset && (state_q != ST_HALT);
   assign ovf    = is_call && (depth_q == DW'(STACK_DEPTH));
   assign unf    = is_ret && (depth_q == '0);
   assign trap   = exec && (!legal || ovf || unf);
   assign retire = exec && !trap;

   always_comb begin
      trap_code = ERR_NONE;
      unique case (1'b1)
         !legal:  trap_code = ERR_ILL;
         ovf:     trap_code = ERR_OVF;
         unf:     trap_code = ERR_UNF;
         default: trap_code = ERR_NONE;
      endcase
   end

   always_comb begin
      bus.s_inc  = 1'b0;
      bus.s_inm  = 1'b0;
      bus.we3    = 1'b0;
      bus.wez    = 1'b0;
      bus.s_pila = 1'b0;
      bus.push   = 1'b0;
      bus.pop    = 1'b0;
      bus.we4    = 1'b0;
      bus.s_data = 1'b0;
      bus.op_alu = 3'b000;
      bus.pc_en  = 1'b0;
      if (retire) begin
         bus.s_inc = 1'b1;
         bus.pc_en = 1'b1;
         unique case (1'b1)
            is_alu: begin
               bus.we3    = 1'b1;
               bus.wez    = 1'b1;
               bus.op_alu = bus.opcode[2:0];
            end
            is_li: begin
               bus.we3   = 1'b1;
               bus.s_inm = 1'b1;
            end
            is_ld: begin
               bus.we3    = 1'b1;
               bus.s_inm  = 1'b1;
               bus.s_data = 1'b1;
            end
            is_st:  bus.we4   = 1'b1;
            is_j:   bus.s_inc = 1'b0;
            is_jz:  bus.s_inc = ~bus.z;
            is_jnz: bus.s_inc = bus.z;
            is_call: begin
               bus.push  = 1'b1;
               bus.s_inc = 1'b0;
            end
            is_ret: begin
               bus.pop    = 1'b1;
               bus.s_pila = 1'b1;
            end
            default: bus.s_inc = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      depth_d = depth_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RUN, ST_STEP: begin
            if (trap) begin
               err_d   = trap_code;
               state_d = ST_HALT;
            end else if (retire) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (is_call) depth_d = depth_q + DW'(1);
               if (is_ret)  depth_d = depth_q - DW'(1);
               if (state_q == ST_STEP || halt_req || is_hlt)
                  state_d = ST_HALT;
               else
                  state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            if (run_req) begin
               state_d = ST_RUN;
               err_d   = ERR_NONE;
            end else if (step_req) begin
               state_d = ST_STEP;
               err_d   = ERR_NONE;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         err_q   <= ERR_NONE;
         depth_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         depth_q <= depth_d;
         cnt_q   <= cnt_d;
      end
   end

   // Status outputs read as zero throughout the reset cycle.
   assign halted    = !reset && (state_q == ST_HALT);
   assign err       = reset ? ERR_NONE : err_q;
   assign depth     = reset ? '0 : depth_q;
   assign instr_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_uc_seq.sv
// Bench for uc_seq: directed scenarios plus random cycles, all
// compared against an instruction-level reference model.
module tb_uc_seq;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_LI   = 6'b001000;
   localparam logic [5:0] OP_LD   = 6'b001001;
   localparam logic [5:0] OP_ST   = 6'b001010;
   localparam logic [5:0] OP_J    = 6'b010000;
   localparam logic [5:0] OP_JZ   = 6'b010001;
   localparam logic [5:0] OP_JNZ  = 6'b010010;
   localparam logic [5:0] OP_CALL = 6'b010011;
   localparam logic [5:0] OP_RET  = 6'b010100;
   localparam logic [5:0] OP_HLT  = 6'b111111;
   localparam logic [5:0] OP_BAD  = 6'b100000;

   logic        clk;
   logic        rst;
   logic        run_r;
   logic        step_r;
   logic        halt_r;
   logic        halted;
   logic [1:0]  err;
   logic [3:0]  depth;
   logic [15:0] instr_cnt;

   int errors = 0;
   int checks = 0;

   // model: 0 running, 1 halted, 2 single step
   int         m_state = 0;
   int         m_depth = 0;
   int         m_cnt   = 0;
   logic [1:0] m_err   = 2'b00;

   logic [35:0] obs;
   logic [35:0] exp;

   uc_seq_if bus ();

   uc_seq #(
      .STACK_DEPTH(8),
      .DW(4),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .reset(rst),
      .bus(bus.master),
      .run_req(run_r),
      .step_req(step_r),
      .halt_req(halt_r),
      .halted(halted),
      .err(err),
      .depth(depth),
      .instr_cnt(instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] trap_of(logic [5:0] o, int d);
      if (!(o[5:3] == 3'b000 || o inside {OP_LI, OP_LD, OP_ST, OP_J,
            OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_HLT}))
         return 2'b11;
      if (o == OP_CALL && d == 8) return 2'b01;
      if (o == OP_RET && d == 0) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [35:0] exp_vec();
      logic s_inc, s_inm, we3, wez, s_pila, push, pop, we4, s_data, pc_en;
      logic [2:0] alu;
      logic [5:0] o;
      o = bus.opcode;
      {s_inc, s_inm, we3, wez, s_pila, push, pop, we4, s_data, pc_en} = '0;
      alu = 3'b000;
      if (!rst && m_state != 1 && trap_of(o, m_depth) == 2'b00) begin
         s_inc = 1'b1;
         pc_en = 1'b1;
         if (o[5:3] == 3'b000) begin
            we3 = 1'b1; wez = 1'b1; alu = o[2:0];
         end
         if (o == OP_LI)   begin we3 = 1'b1; s_inm = 1'b1; end
         if (o == OP_LD)   begin we3 = 1'b1; s_inm = 1'b1; s_data = 1'b1; end
         if (o == OP_ST)   we4 = 1'b1;
         if (o == OP_J)    s_inc = 1'b0;
         if (o == OP_JZ)   s_inc = !bus.z;
         if (o == OP_JNZ)  s_inc = bus.z;
         if (o == OP_CALL) begin push = 1'b1; s_inc = 1'b0; end
         if (o == OP_RET)  begin pop = 1'b1; s_pila = 1'b1; end
      end
      if (rst)
         return {s_inc, s_inm, we3, wez, s_pila, push, pop, we4, s_data,
                 alu, pc_en, 1'b0, 2'b00, 4'd0, 16'd0};
      return {s_inc, s_inm, we3, wez, s_pila, push, pop, we4, s_data,
              alu, pc_en, (m_state == 1), m_err, 4'(m_depth), 16'(m_cnt)};
   endfunction

   function automatic logic [35:0] obs_vec();
      return {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.s_pila,
              bus.push, bus.pop, bus.we4, bus.s_data, bus.op_alu,
              bus.pc_en, halted, err, depth, instr_cnt};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_state <= 0; m_depth <= 0; m_err <= 2'b00; m_cnt <= 0;
      end else if (m_state == 1) begin
         if (run_r) begin
            m_state <= 0; m_err <= 2'b00;
         end else if (step_r) begin
            m_state <= 2; m_err <= 2'b00;
         end
      end else if (trap_of(bus.opcode, m_depth) != 2'b00) begin
         m_err   <= trap_of(bus.opcode, m_depth);
         m_state <= 1;
      end else begin
         m_cnt <= (m_cnt + 1) % 65536;
         if (bus.opcode == OP_CALL) m_depth <= m_depth + 1;
         if (bus.opcode == OP_RET)  m_depth <= m_depth - 1;
         m_state <= (m_state == 2 || halt_r || bus.opcode == OP_HLT) ? 1 : 0;
      end
   end

   task automatic drv(input logic [5:0] o, input logic zz, input logic r,
                      input logic s, input logic h, input logic rs);
      @(negedge clk);
      bus.opcode = o;
      bus.z      = zz;
      run_r      = r;
      step_r     = s;
      halt_r     = h;
      rst        = rs;
      #1;
      obs = obs_vec();
      exp = exp_vec();
   endtask

   task automatic test_reset();
      drv(OP_CALL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(OP_CALL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, 36'd0);
      end
   endtask

   task automatic test_stream();
      logic [5:0] ops [4];
      ops = '{OP_ADD, OP_LI, OP_ST, OP_HLT};
      for (int i = 0; i < 4; i++) begin
         drv(ops[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL stream[%0d] got=%h exp=%h", i, obs, exp);
         end
      end
      drv(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (halted !== 1'b1 || instr_cnt !== 16'd4 || bus.pc_en !== 1'b0) begin
         errors++;
         $display("FAIL stream_halt halted=%b cnt=%0d pc_en=%b exp 1/4/0",
                  halted, instr_cnt, bus.pc_en);
      end
   endtask

   task automatic test_branches();
      logic [5:0] ops [4];
      logic       zs  [4];
      logic       inc [4];
      ops = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ};
      zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
      inc = '{1'b0, 1'b1, 1'b1, 1'b0};
      drv(OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drv(ops[i], zs[i], 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (bus.s_inc !== inc[i] || bus.pc_en !== 1'b1 || obs !== exp) begin
            errors++;
            $display("FAIL branch[%0d] s_inc=%b pc_en=%b got=%h exp=%h",
                     i, bus.s_inc, bus.pc_en, obs, exp);
         end
      end
   endtask

   task automatic test_stack();
      for (int i = 0; i < 9; i++) begin
         drv(OP_CALL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL call[%0d] got=%h exp=%h", i, obs, exp);
         end
      end
      checks++;
      if (bus.push !== 1'b0 || bus.pc_en !== 1'b0 || depth !== 4'd8) begin
         errors++;
         $display("FAIL call_ovf push=%b pc_en=%b depth=%0d exp 0/0/8",
                  bus.push, bus.pc_en, depth);
      end
      drv(OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (err !== 2'b01 || halted !== 1'b1 || depth !== 4'd8) begin
         errors++;
         $display("FAIL ovf_trap err=%b halted=%b depth=%0d exp 01/1/8",
                  err, halted, depth);
      end
      drv(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (err !== 2'b00 || halted !== 1'b0 || bus.we3 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_resume err=%b halted=%b we3=%b exp 00/0/1",
                  err, halted, bus.we3);
      end
   endtask

   task automatic test_underflow_illegal();
      logic [15:0] cnt0;
      for (int i = 0; i < 9; i++) begin
         drv(OP_RET, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL ret[%0d] got=%h exp=%h", i, obs, exp);
         end
      end
      drv(OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (err !== 2'b10 || halted !== 1'b1 || depth !== 4'd0) begin
         errors++;
         $display("FAIL unf_trap err=%b halted=%b depth=%0d exp 10/1/0",
                  err, halted, depth);
      end
      drv(OP_BAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cnt0 = instr_cnt;
      checks++;
      if (bus.pc_en !== 1'b0 || obs !== exp) begin
         errors++;
         $display("FAIL illegal pc_en=%b got=%h exp=%h", bus.pc_en, obs, exp);
      end
      drv(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (err !== 2'b11 || halted !== 1'b1 || instr_cnt !== cnt0) begin
         errors++;
         $display("FAIL illegal_trap err=%b halted=%b cnt=%0d exp 11/1/%0d",
                  err, halted, instr_cnt, cnt0);
      end
   endtask

   task automatic test_step();
      logic [15:0] cnt0;
      logic [5:0]  o;
      cnt0 = instr_cnt;
      for (int i = 0; i < 3; i++) begin
         drv(OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (halted !== 1'b1 || bus.pc_en !== 1'b0) begin
            errors++;
            $display("FAIL step_wait[%0d] halted=%b pc_en=%b exp 1/0",
                     i, halted, bus.pc_en);
         end
         o = {3'b000, 3'($urandom)};
         drv(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (bus.op_alu !== o[2:0] || obs !== exp) begin
            errors++;
            $display("FAIL step_exec[%0d] got=%h exp=%h", i, obs, exp);
         end
      end
      drv(OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (halted !== 1'b1 || instr_cnt !== cnt0 + 16'd3) begin
         errors++;
         $display("FAIL step_count halted=%b cnt=%0d exp 1/%0d",
                  halted, instr_cnt, cnt0 + 16'd3);
      end
      drv(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drv(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (halted !== 1'b0 || instr_cnt !== cnt0 + 16'd4) begin
         errors++;
         $display("FAIL run_prio halted=%b cnt=%0d exp 0/%0d",
                  halted, instr_cnt, cnt0 + 16'd4);
      end
   endtask

   task automatic test_reset_mid();
      drv(OP_CALL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drv(OP_CALL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.push !== 1'b0 || depth !== 4'd0 || instr_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid push=%b depth=%0d cnt=%0d exp 0/0/0",
                  bus.push, depth, instr_cnt);
      end
      drv(OP_CALL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (halted !== 1'b0 || bus.push !== 1'b1 || obs !== exp) begin
         errors++;
         $display("FAIL reset_release got=%h exp=%h", obs, exp);
      end
   endtask

   task automatic test_random();
      logic [5:0] o;
      for (int i = 0; i < 500; i++) begin
         case ($urandom_range(0, 11))
            0, 1:    o = {3'b000, 3'($urandom)};
            2:       o = OP_LI;
            3:       o = OP_LD;
            4:       o = OP_ST;
            5:       o = OP_J;
            6:       o = ($urandom_range(0, 1) == 0) ? OP_JZ : OP_JNZ;
            7, 8:    o = OP_CALL;
            9:       o = OP_RET;
            10:      o = ($urandom_range(0, 3) == 0) ? OP_HLT : OP_ADD;
            default: o = 6'($urandom);
         endcase
         drv(o, 1'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 63) == 0));
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random[%0d] op=%b got=%h exp=%h", i, o, obs, exp);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      run_r      = 1'b0;
      step_r     = 1'b0;
      halt_r     = 1'b0;
      bus.opcode = OP_ADD;
      bus.z      = 1'b0;
      test_reset();
      test_stream();
      test_branches();
      test_stack();
      test_underflow_illegal();
      test_step();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
